// File: rtl/sacc_pkg.sv
// Shared widths, FSM state type and the round/shift/saturate helper for the
// integrate-and-dump accumulator and its downstream stages.
package sacc_pkg;

  localparam int unsigned SACC_IWIDTH = 33;
  localparam int unsigned SACC_OWIDTH = 16;
  localparam int unsigned SACC_LWIDTH = 8;
  localparam int unsigned SACC_SWIDTH = 6;
  localparam int unsigned SACC_ACCW   = SACC_IWIDTH + SACC_LWIDTH;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } sacc_state_t;

  typedef struct packed {
    logic                          sat;
    logic signed [SACC_OWIDTH-1:0] val;
  } sround_t;

  // Round half-up, arithmetic shift right, clamp to the signed output range.
  function automatic sround_t sat_round(input logic signed [SACC_ACCW-1:0] acc,
                                        input logic [SACC_SWIDTH-1:0]       shift);
    logic [SACC_SWIDTH-1:0]      sh;
    logic signed [SACC_ACCW:0]   ext;
    logic signed [SACC_ACCW:0]   bias;
    logic signed [SACC_ACCW:0]   shd;
    logic signed [SACC_ACCW:0]   omax;
    logic signed [SACC_ACCW:0]   omin;
    sround_t                     r;
    sh   = (32'(shift) >= SACC_ACCW) ? SACC_SWIDTH'(SACC_ACCW - 1) : shift;
    ext  = (SACC_ACCW + 1)'(acc);
    bias = '0;
    if (sh != '0) bias[sh - SACC_SWIDTH'(1)] = 1'b1;
    shd  = (ext + bias) >>> sh;
    omax = '0;
    omax[SACC_OWIDTH-2:0] = '1;
    omin = ~omax;
    r.sat = (shd > omax) || (shd < omin);
    if (shd > omax)      r.val = omax[SACC_OWIDTH-1:0];
    else if (shd < omin) r.val = omin[SACC_OWIDTH-1:0];
    else                 r.val = shd[SACC_OWIDTH-1:0];
    return r;
  endfunction

endpackage

// File: rtl/sround_sat.sv
// Registered round/shift/saturate stage with valid pass-through and a
// synchronous cancel that drops the result being captured.
module sround_sat
  import sacc_pkg::*;
(
  input  logic                          clk,
  input  logic                          aclr,
  input  logic                          cancel,
  input  logic                          in_valid,
  input  logic signed [SACC_ACCW-1:0]   acc,
  input  logic [SACC_SWIDTH-1:0]        shift,
  output logic signed [SACC_OWIDTH-1:0] dout,
  output logic                          dout_valid,
  output logic                          dout_sat
);

  sround_t res_c;

  always_comb begin
    res_c = sat_round(acc, shift);
  end

  // dout holds between pulses; cancel only suppresses the pulse.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_sat   <= 1'b0;
    end else if (cancel) begin
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= in_valid;
      if (in_valid) begin
        dout     <= res_c.val;
        dout_sat <= res_c.sat;
      end
    end
  end

endmodule

// File: rtl/sacc_dump.sv
// Integrate-and-dump accumulator: sums a programmable number of signed
// products per frame and emits a rounded, shifted, saturated result.
module sacc_dump
  import sacc_pkg::*;
#(
  parameter int unsigned IWIDTH = SACC_IWIDTH,
  parameter int unsigned OWIDTH = SACC_OWIDTH,
  parameter int unsigned LWIDTH = SACC_LWIDTH,
  parameter int unsigned SWIDTH = SACC_SWIDTH
) (
  input  logic                     clk,
  input  logic                     aclr,
  input  logic                     clr,
  input  logic signed [IWIDTH-1:0] din,
  input  logic                     din_valid,
  input  logic [LWIDTH-1:0]        len,
  input  logic [SWIDTH-1:0]        shift,
  output logic signed [OWIDTH-1:0] dout,
  output logic                     dout_valid,
  output logic                     dout_sat,
  output logic                     busy
);

  localparam int unsigned ACCW = IWIDTH + LWIDTH;

  sacc_state_t             state;
  sacc_state_t             state_next;
  logic signed [ACCW-1:0]  acc;
  logic [LWIDTH-1:0]       count;
  logic [LWIDTH-1:0]       len_q;
  logic [SWIDTH-1:0]       shift_q;
  logic signed [ACCW-1:0]  dump_acc;
  logic [SWIDTH-1:0]       dump_shift;
  logic                    dump_valid;

  logic [LWIDTH-1:0]       len_eff_c;
  logic                    last_c;
  logic signed [ACCW-1:0]  din_ext_c;
  logic signed [ACCW-1:0]  sum_c;
  logic                    open_c;
  logic                    add_c;
  logic                    dump_one_c;
  logic                    dump_sum_c;

  always_comb begin
    len_eff_c = (len == '0) ? LWIDTH'(1) : len;
    last_c    = (count == len_q - LWIDTH'(1));
    din_ext_c = ACCW'(din);
    sum_c     = acc + din_ext_c;
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (din_valid && len_eff_c > LWIDTH'(1)) state_next = ACCUM;
      ACCUM:   if (din_valid && last_c)                 state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (clr) state_next = IDLE;
  end

  // Datapath strobes; clr drops any sample presented in the same cycle.
  always_comb begin
    open_c     = 1'b0;
    add_c      = 1'b0;
    dump_one_c = 1'b0;
    dump_sum_c = 1'b0;
    if (!clr && din_valid) begin
      case (state)
        IDLE: begin
          if (len_eff_c > LWIDTH'(1)) open_c     = 1'b1;
          else                        dump_one_c = 1'b1;
        end
        ACCUM: begin
          if (last_c) dump_sum_c = 1'b1;
          else        add_c      = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      acc        <= '0;
      count      <= '0;
      len_q      <= '0;
      shift_q    <= '0;
      dump_acc   <= '0;
      dump_shift <= '0;
      dump_valid <= 1'b0;
      busy       <= 1'b0;
    end else if (clr) begin
      acc        <= '0;
      count      <= '0;
      dump_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      busy       <= (state_next == ACCUM);
      dump_valid <= dump_one_c | dump_sum_c;
      if (open_c) begin
        acc     <= din_ext_c;
        count   <= LWIDTH'(1);
        len_q   <= len_eff_c;
        shift_q <= shift;
      end
      if (add_c) begin
        acc   <= sum_c;
        count <= count + LWIDTH'(1);
      end
      if (dump_one_c) begin
        dump_acc   <= din_ext_c;
        dump_shift <= shift;
      end
      if (dump_sum_c) begin
        dump_acc   <= sum_c;
        dump_shift <= shift_q;
        acc        <= '0;
        count      <= '0;
      end
    end
  end

  sround_sat u_sround_sat (
    .clk        (clk),
    .aclr       (aclr),
    .cancel     (clr),
    .in_valid   (dump_valid),
    .acc        (dump_acc),
    .shift      (dump_shift),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_sat   (dout_sat)
  );

endmodule

// File: tb/tb_sacc_dump.sv
// Scoreboard bench for sacc_dump: a frame model pushes expected results with
// their due time, a negedge monitor pops and compares each output pulse.
module tb_sacc_dump;

  logic               clk;
  logic               aclr;
  logic               clr;
  logic signed [32:0] din;
  logic               din_valid;
  logic [7:0]         len;
  logic [5:0]         shift;
  logic signed [15:0] dout;
  logic               dout_valid;
  logic               dout_sat;
  logic               busy;

  typedef struct {
    longint val;
    bit     sat;
    longint t;
  } exp_t;

  exp_t   sb[$];
  int     n_checks = 0;
  int     n_fail   = 0;

  bit     m_open = 0;
  longint m_acc  = 0;
  int     m_cnt  = 0;
  int     m_len  = 0;
  int     m_sh   = 0;

  sacc_dump dut (
    .clk        (clk),
    .aclr       (aclr),
    .clr        (clr),
    .din        (din),
    .din_valid  (din_valid),
    .len        (len),
    .shift      (shift),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_sat   (dout_sat),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected frame result, due at the negedge 1.5 cycles after the capture edge.
  task automatic push(input longint s, input int sh);
    exp_t e;
    longint v;
    v = s;
    if (sh >= 41) sh = 40;
    if (sh > 0) v = v + (longint'(1) << (sh - 1));
    v = v >>> sh;
    e.sat = 1'b0;
    if (v > 32767)  begin v = 32767;  e.sat = 1'b1; end
    if (v < -32768) begin v = -32768; e.sat = 1'b1; end
    e.val = v;
    e.t   = longint'($time) + 15;
    sb.push_back(e);
  endtask

  task automatic step(input logic v, input longint d, input logic c = 1'b0);
    int eff;
    din_valid = v;
    din       = 33'(d);
    clr       = c;
    @(posedge clk);
    if (c) begin
      m_open = 0;
      m_acc  = 0;
      m_cnt  = 0;
      while (sb.size() > 0 && sb[$].t > longint'($time)) void'(sb.pop_back());
    end else if (v) begin
      if (!m_open) begin
        eff = (len == 8'd0) ? 1 : int'(len);
        if (eff == 1) push(d, int'(shift));
        else begin
          m_open = 1;
          m_len  = eff;
          m_sh   = int'(shift);
          m_acc  = d;
          m_cnt  = 1;
        end
      end else begin
        m_acc = m_acc + d;
        m_cnt++;
        if (m_cnt == m_len) begin
          push(m_acc, m_sh);
          m_open = 0;
          m_acc  = 0;
          m_cnt  = 0;
        end
      end
    end
    #1;
    check("busy", longint'(busy), longint'(m_open));
  endtask

  always @(negedge clk) begin
    if (!aclr) begin
      if (dout_valid) begin
        if (sb.size() == 0) check("spurious_pulse", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("latency", longint'($time), e.t);
          check("dout", longint'(dout), e.val);
          check("dout_sat", longint'(dout_sat), longint'(e.sat));
        end
      end else if (sb.size() > 0 && sb[0].t <= longint'($time)) begin
        check("missing_pulse", 0, 1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    aclr      = 1'b1;
    clr       = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    len       = 8'd4;
    shift     = 6'd2;
    #12;
    check("rst_dout", longint'(dout), 0);
    check("rst_valid", longint'(dout_valid), 0);
    check("rst_sat", longint'(dout_sat), 0);
    check("rst_busy", longint'(busy), 0);
    @(negedge clk);
    aclr = 1'b0;
    step(0, 0);

    // 1: basic frame; len/shift changes mid-frame must be ignored
    len = 8'd4; shift = 6'd2;
    step(1, 10);
    len = 8'd9; shift = 6'd5;
    step(1, 20);
    step(1, 30);
    step(1, 41);
    step(0, 0);
    step(0, 0);

    // 2: round half-up for both signs
    len = 8'd2; shift = 6'd1;
    step(1, -3); step(1, -2);
    step(1, 3);  step(1, 2);
    step(0, 0);

    // 3: saturation both directions
    shift = 6'd0;
    step(1, 30000);  step(1, 30000);
    step(1, -40000); step(1, -1);
    step(0, 0);

    // 4: back-to-back frames, continuous valid
    len = 8'd3;
    for (int i = 1; i <= 6; i++) step(1, i);
    step(0, 0);

    // pause mid-frame
    step(1, 5); step(0, 0); step(0, 0); step(1, 6); step(1, 7);
    step(0, 0);

    // 5: len 0 and 1 dump every sample; shift clamp
    len = 8'd0;
    for (int i = 0; i < 3; i++) step(1, 7);
    len = 8'd1;
    for (int i = 0; i < 3; i++) step(1, 7);
    shift = 6'd63;
    step(1, -5);
    step(1, 64'sd4294967296);
    step(0, 0); step(0, 0);

    // 6: clr mid-frame with a sample that must be dropped
    len = 8'd4; shift = 6'd0;
    step(1, 100); step(1, 100);
    step(1, 555, 1'b1);
    for (int i = 0; i < 4; i++) step(1, 1);
    step(0, 0); step(0, 0); step(0, 0);

    // aclr mid-frame: outputs drop immediately
    step(1, 100); step(1, 100);
    #2;
    aclr = 1'b1;
    #1;
    check("aclr_dout", longint'(dout), 0);
    check("aclr_valid", longint'(dout_valid), 0);
    check("aclr_sat", longint'(dout_sat), 0);
    check("aclr_busy", longint'(busy), 0);
    m_open = 0; m_acc = 0; m_cnt = 0;
    sb.delete();
    @(negedge clk);
    aclr = 1'b0;
    shift = 6'd1;
    for (int i = 0; i < 4; i++) step(1, 2);
    for (int i = 0; i < 5; i++) step(0, 0);

    check("scoreboard_drained", longint'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
